// File: rtl/mod_counter.sv
// Up/down modulo-(MAX+1) counter with enable, clamped parallel load, cascade carry,
// registered terminal-count pulse and a one-shot mode that freezes in DONE.
module mod_counter #(
  parameter int               WIDTH = 26,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             CE,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             ONESHOT,
  output logic [WIDTH-1:0] O,
  output logic             COUT,
  output logic             TC,
  output logic             DONE
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] count, count_next;
  logic             tc_q, tc_next;
  logic             term;
  logic             term_event;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= ST_RUN;
      count <= '0;
      tc_q  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      tc_q  <= tc_next;
    end
  end

  // Terminal event doubles as the cascade carry, so it must be qualified by
  // everything that would stop this stage from actually wrapping this edge.
  always_comb begin
    term       = UP ? (count == MAX) : (count == '0);
    term_event = CE && !LD && RESETN && (state == ST_RUN) && term;
    state_next = state;
    count_next = count;
    tc_next    = 1'b0;
    if (LD) begin
      state_next = ST_RUN;
      count_next = (D > MAX) ? MAX : D;
    end else if (CE && (state == ST_RUN)) begin
      tc_next = term_event;
      if (term && ONESHOT) begin
        state_next = ST_DONE;
      end else if (UP) begin
        count_next = term ? '0 : count + WIDTH'(1);
      end else begin
        count_next = term ? MAX : count - WIDTH'(1);
      end
    end
  end

  assign O    = count;
  assign COUT = term_event;
  assign TC   = tc_q;
  assign DONE = (state == ST_DONE);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MAX=9) using an expected-result
// queue, plus a two-stage BCD cascade check.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       resetn, ce, up, ld, oneshot;
  logic [3:0] d;
  logic [3:0] o;
  logic       cout, tc, done;

  logic       casc_resetn, casc_ce;
  logic [3:0] lo_o, hi_o;
  logic       lo_cout, hi_cout, lo_tc, hi_tc, lo_done, hi_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int o;
    int tc;
    int done;
  } exp_t;

  exp_t exp_q[$];

  int m_o    = 0;
  int m_tc   = 0;
  int m_done = 0;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MAX(4'd9)) dut (
    .CLK(clk), .RESETN(resetn), .CE(ce), .UP(up), .LD(ld), .D(d),
    .ONESHOT(oneshot), .O(o), .COUT(cout), .TC(tc), .DONE(done)
  );

  mod_counter #(.WIDTH(4), .MAX(4'd9)) casc_lo (
    .CLK(clk), .RESETN(casc_resetn), .CE(casc_ce), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .ONESHOT(1'b0), .O(lo_o), .COUT(lo_cout), .TC(lo_tc), .DONE(lo_done)
  );

  mod_counter #(.WIDTH(4), .MAX(4'd9)) casc_hi (
    .CLK(clk), .RESETN(casc_resetn), .CE(lo_cout), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .ONESHOT(1'b0), .O(hi_o), .COUT(hi_cout), .TC(hi_tc), .DONE(hi_done)
  );

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  // Drives one cycle: checks the combinational carry, queues the model's
  // post-edge expectation, then pops and compares it after the edge.
  task automatic applyStimulus(input logic r, input logic c, input logic u,
                               input logic l, input int dv, input logic os);
    int   term;
    int   ev;
    exp_t e;
    @(negedge clk);
    resetn  = r;
    ce      = c;
    up      = u;
    ld      = l;
    d       = 4'(dv);
    oneshot = os;
    #1;
    term = u ? (m_o == 9) : (m_o == 0);
    ev   = (c && !l && r && !m_done && term) ? 1 : 0;
    checkOutput("cout", int'(cout), ev);
    if (!r) begin
      m_o = 0; m_tc = 0; m_done = 0;
    end else if (l) begin
      m_o = (dv > 9) ? 9 : dv; m_tc = 0; m_done = 0;
    end else begin
      m_tc = ev;
      if (c && !m_done) begin
        if (ev && os) m_done = 1;
        else m_o = u ? (m_o + 1) % 10 : (m_o + 9) % 10;
      end
    end
    e.o = m_o; e.tc = m_tc; e.done = m_done;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checkOutput("o", int'(o), e.o);
    checkOutput("tc", int'(tc), e.tc);
    checkOutput("done", int'(done), e.done);
  endtask

  initial begin
    resetn = 1'b0; ce = 1'b0; up = 1'b1; ld = 1'b0; d = 4'd0; oneshot = 1'b0;
    casc_resetn = 1'b0; casc_ce = 1'b0;

    applyStimulus(0, 1, 1, 1, 5, 0);
    applyStimulus(0, 0, 1, 0, 0, 0);

    // Count up through a wrap: 1..9,0,1,2, then on to 0.
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("at_zero", int'(o), 0);
    // Down from 0 wraps to 9, then reverse direction at 5.
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0);
    checkOutput("reverse", int'(o), 6);

    applyStimulus(1, 1, 1, 1, 7, 0);
    applyStimulus(1, 1, 1, 1, 14, 0);
    checkOutput("clamp", int'(o), 9);
    applyStimulus(0, 1, 1, 1, 5, 0);

    // One-shot: 7 -> 8, 9, then frozen in DONE.
    applyStimulus(1, 0, 1, 1, 7, 1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 1, 1, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("done_hold", int'(o), 9);
    applyStimulus(1, 1, 1, 1, 2, 0);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0);

    // CE toggling with a reset pulse once the count reaches 4.
    applyStimulus(1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(1, (i % 2 == 0), 1, 0, 0, 0);
    checkOutput("toggle", int'(o), 4);
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, (i % 2 == 0), 1, 0, 0, 0);

    // Randomised mix of all controls.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    // Two-stage BCD cascade: pair value follows the cycle count modulo 100.
    @(negedge clk);
    casc_resetn = 1'b0;
    @(negedge clk);
    casc_resetn = 1'b1;
    casc_ce     = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      checkOutput("casc_cout", int'(hi_cout), (k == 99) ? 1 : 0);
      @(posedge clk);
      #1;
      checkOutput("casc_pair", int'(hi_o) * 10 + int'(lo_o), (k + 1) % 100);
      @(negedge clk);
    end
    casc_ce = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
